// File: rtl/ascan_capture.sv
// ascan_capture: per-pulse A-scan capture into a buffer, streamed out as a framed byte stream
module ascan_capture #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int DELAY_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              trig_in,
    input  logic [DATA_W-1:0] ad_in1,
    input  logic [DATA_W-1:0] ad_in2,
    input  logic [7:0]        position,
    input  logic              m_wr,
    input  logic [7:0]        m_addr,
    input  logic [15:0]       m_wrdata,
    output logic [7:0]        frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_sof,
    output logic              frame_eof,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef logic [ADDR_W:0] len_t;
    localparam len_t DEPTH_L = len_t'(DEPTH);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {IDLE, DELAY, CAPTURE, HEADER, READOUT} state_t;

    state_t              state;
    logic                trig_r, edge_det, cfg_ch, w_ch, load_sample;
    logic [DELAY_W-1:0]  cfg_delay, dcnt;
    len_t                cfg_len, w_len, rcnt, len_wr;
    logic [7:0]          w_pos, seq, hdr_nxt;
    logic [ADDR_W-1:0]   wptr, rptr, rptr_n;
    logic [2:0]          hidx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data, sample;

    assign busy = state != IDLE;

    // rd_data always tracks mem[rptr]; rptr advances the same cycle a sample is loaded
    always_comb begin
        edge_det    = trig_in & ~trig_r;
        sample      = w_ch ? ad_in2 : ad_in1;
        load_sample = frame_ready && ((state == HEADER && hidx == 3'd5) || (state == READOUT && rcnt != w_len));
        rptr_n      = load_sample ? rptr + ADDR_W'(1) : rptr;
        len_wr      = (m_wrdata == 16'd0 || m_wrdata > DEPTH16) ? DEPTH_L : m_wrdata[ADDR_W:0];
        hdr_nxt     = hidx == 3'd0 ? 8'h5A :
                      hidx == 3'd1 ? w_pos :
                      hidx == 3'd2 ? seq :
                      hidx == 3'd3 ? 8'(w_len >> 8) : 8'(w_len);
    end

    always_ff @(posedge Clk) begin
        if (state == CAPTURE) mem[wptr] <= sample;
        rd_data <= mem[rptr_n];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            trig_r      <= 1'b0;
            frame_valid <= 1'b0;
            frame_sof   <= 1'b0;
            frame_eof   <= 1'b0;
            frame_data  <= 8'd0;
            overrun_cnt <= 8'd0;
            seq         <= 8'd0;
            cfg_delay   <= '0;
            cfg_len     <= DEPTH_L;
            cfg_ch      <= 1'b0;
            w_len       <= DEPTH_L;
            w_ch        <= 1'b0;
            w_pos       <= 8'd0;
            dcnt        <= '0;
            wptr        <= '0;
            rptr        <= '0;
            rcnt        <= '0;
            hidx        <= 3'd0;
        end else begin
            trig_r    <= trig_in;
            rptr      <= rptr_n;
            cfg_delay <= (m_wr && m_addr == 8'h20) ? m_wrdata[DELAY_W-1:0] : cfg_delay;
            cfg_len   <= (m_wr && m_addr == 8'h21) ? len_wr : cfg_len;
            cfg_ch    <= (m_wr && m_addr == 8'h22) ? m_wrdata[0] : cfg_ch;
            if (edge_det && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                IDLE: if (edge_det) begin
                    w_len <= cfg_len;
                    w_ch  <= cfg_ch;
                    w_pos <= position;
                    dcnt  <= cfg_delay - DELAY_W'(1);
                    wptr  <= '0;
                    state <= cfg_delay == '0 ? CAPTURE : DELAY;
                end
                DELAY: begin
                    dcnt <= dcnt - DELAY_W'(1);
                    if (dcnt == '0) state <= CAPTURE;
                end
                CAPTURE: begin
                    wptr <= wptr + ADDR_W'(1);
                    if (len_t'(wptr) == w_len - len_t'(1)) begin
                        state       <= HEADER;
                        hidx        <= 3'd0;
                        rptr        <= '0;
                        frame_valid <= 1'b1;
                        frame_sof   <= 1'b1;
                        frame_data  <= 8'hA5;
                    end
                end
                HEADER: if (frame_ready) begin
                    hidx       <= hidx + 3'd1;
                    frame_sof  <= 1'b0;
                    frame_data <= hidx == 3'd5 ? 8'(rd_data) : hdr_nxt;
                    if (hidx == 3'd5) begin
                        state     <= READOUT;
                        rcnt      <= len_t'(1);
                        frame_eof <= w_len == len_t'(1);
                    end
                end
                READOUT: if (frame_ready) begin
                    if (rcnt == w_len) begin
                        frame_valid <= 1'b0;
                        frame_eof   <= 1'b0;
                        seq         <= seq + 8'd1;
                        state       <= IDLE;
                    end else begin
                        frame_data <= 8'(rd_data);
                        rcnt       <= rcnt + len_t'(1);
                        frame_eof  <= rcnt + len_t'(1) == w_len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
